// File: rtl/bcd_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module : bcd_timer_pkg
// Brief  : Shared BCD constants, load clamp helper and default prescaler width.
// Rev    : 1.0
// ============================================================================
package bcd_timer_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    localparam int DEF_CLK_HZ  = 50_000_000;
    localparam int DEF_TICK_HZ = 1;
    localparam int DEF_DIV     = DEF_CLK_HZ / DEF_TICK_HZ;
    localparam int DIV_W       = $clog2(DEF_DIV);

    function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_timer_if.sv
`default_nettype none
// ============================================================================
// Module : bcd_timer_if
// Brief  : Control and display bundle between key logic and the BCD timer.
// Rev    : 1.0
// ============================================================================
interface bcd_timer_if #(
    parameter int NUM_DIGITS = 3
);
    logic                    clear;
    logic                    run;
    logic                    dir;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] load_val;
    logic                    lap;
    logic [4*NUM_DIGITS-1:0] count_bcd;
    logic [4*NUM_DIGITS-1:0] disp_bcd;
    logic                    tick_o;
    logic                    tc_o;
    logic                    done;

    modport master (
        output clear, run, dir, load, load_val, lap,
        input  count_bcd, disp_bcd, tick_o, tc_o, done
    );

    modport slave (
        input  clear, run, dir, load, load_val, lap,
        output count_bcd, disp_bcd, tick_o, tc_o, done
    );
endinterface
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
// Module : bcd_digit
// Brief  : One BCD digit register with up/down step, clear and clamped load.
// Rev    : 1.0
// ============================================================================
module bcd_digit
    import bcd_timer_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_en,
    input  wire logic       i_dir,
    input  wire logic       i_clr,
    input  wire logic       i_ld,
    input  wire logic [3:0] i_ld_val,
    output logic      [3:0] o_q,
    output logic            o_term
);
    logic [3:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= BCD_MIN;
        end else if (i_clr) begin
            r_q <= BCD_MIN;
        end else if (i_ld) begin
            r_q <= clamp_bcd(i_ld_val);
        end else if (i_en) begin
            if (i_dir) begin
                r_q <= (r_q == BCD_MIN) ? BCD_MAX : r_q - 4'd1;
            end else begin
                r_q <= (r_q >= BCD_MAX) ? BCD_MIN : r_q + 4'd1;
            end
        end
    end

    // Terminal digit: the next step in the current direction carries/borrows out
    assign o_term = i_dir ? (r_q == BCD_MIN) : (r_q == BCD_MAX);
    assign o_q    = r_q;

endmodule
`default_nettype wire

// File: rtl/bcd_timer_n.sv
`default_nettype none
// ============================================================================
// Module : bcd_timer_n
// Brief  : N-digit BCD timer with prescaler, up/down, load, lap hold, wrap/sat.
// Rev    : 1.0
// ============================================================================
module bcd_timer_n
    import bcd_timer_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 1,
    parameter int WRAP       = 1
) (
    input  wire logic   clk,
    input  wire logic   rst,
    bcd_timer_if.slave  bus
);
    localparam int                 PRESC_DIV  = CLK_HZ / TICK_HZ;
    localparam int                 PRESC_W    = $clog2(PRESC_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);
    localparam int                 CW         = 4 * NUM_DIGITS;
    localparam bit                 SAT        = (WRAP == 0);

    logic [PRESC_W-1:0]    r_presc;
    logic                  r_done;
    logic                  r_tick;
    logic                  r_tc;
    logic                  r_lap_d;
    logic [CW-1:0]         r_snap;

    logic [CW-1:0]         w_count;
    logic [NUM_DIGITS-1:0] w_term;
    logic [NUM_DIGITS-1:0] w_en;
    logic                  w_adv;
    logic                  w_end;
    logic                  w_step;
    logic                  w_ovr;

    assign w_adv  = bus.run & ~r_done & (r_presc == PRESC_LAST);
    assign w_end  = w_adv & (&w_term);
    // Saturating mode swallows the step at range end so the count holds
    assign w_step = w_adv & ~(w_end & SAT);
    assign w_ovr  = bus.clear | bus.load;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        if (k == 0) begin : g_first
            assign w_en[k] = w_step;
        end else begin : g_rest
            assign w_en[k] = w_step & (&w_term[k-1:0]);
        end

        bcd_digit u_digit (
            .clk      (clk),
            .rst      (rst),
            .i_en     (w_en[k]),
            .i_dir    (bus.dir),
            .i_clr    (bus.clear),
            .i_ld     (bus.load),
            .i_ld_val (bus.load_val[4*k +: 4]),
            .o_q      (w_count[4*k +: 4]),
            .o_term   (w_term[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_presc <= '0;
            r_done  <= 1'b0;
            r_tick  <= 1'b0;
            r_tc    <= 1'b0;
            r_lap_d <= 1'b0;
            r_snap  <= '0;
        end else begin
            r_lap_d <= bus.lap;
            r_tick  <= w_adv & ~w_ovr;
            r_tc    <= w_end & ~w_ovr;

            if (w_ovr) begin
                r_presc <= '0;
                r_done  <= 1'b0;
            end else if (bus.run && !r_done) begin
                r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PRESC_W'(1);
                if (w_end && SAT) begin
                    r_done <= 1'b1;
                end
            end

            if (bus.clear) begin
                r_snap <= '0;
            end else if (bus.lap && !r_lap_d) begin
                r_snap <= w_count;
            end
        end
    end

    // In the lap-rise cycle the snapshot is not yet loaded, so show the live value
    assign bus.disp_bcd  = (bus.lap && r_lap_d) ? r_snap : w_count;
    assign bus.count_bcd = w_count;
    assign bus.tick_o    = r_tick;
    assign bus.tc_o      = r_tc;
    assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bcd_timer_n.sv
`default_nettype none
// ============================================================================
// Module : tb_bcd_timer_n
// Brief  : Directed self-checking bench for bcd_timer_n (DIV=4, three configs).
// Rev    : 1.0
// ============================================================================
module tb_bcd_timer_n;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    bcd_timer_if #(.NUM_DIGITS(3)) a_if ();
    bcd_timer_if #(.NUM_DIGITS(2)) b_if ();
    bcd_timer_if #(.NUM_DIGITS(3)) c_if ();

    bcd_timer_n #(.NUM_DIGITS(3), .CLK_HZ(4), .TICK_HZ(1), .WRAP(1)) u_dut_a (
        .clk (clk), .rst (rst), .bus (a_if)
    );
    bcd_timer_n #(.NUM_DIGITS(2), .CLK_HZ(4), .TICK_HZ(1), .WRAP(1)) u_dut_b (
        .clk (clk), .rst (rst), .bus (b_if)
    );
    bcd_timer_n #(.NUM_DIGITS(3), .CLK_HZ(4), .TICK_HZ(1), .WRAP(0)) u_dut_c (
        .clk (clk), .rst (rst), .bus (c_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b0;
        a_if.clear = 0; a_if.run = 1; a_if.dir = 0; a_if.load = 0; a_if.load_val = '0; a_if.lap = 0;
        b_if.clear = 0; b_if.run = 0; b_if.dir = 0; b_if.load = 0; b_if.load_val = '0; b_if.lap = 0;
        c_if.clear = 0; c_if.run = 0; c_if.dir = 0; c_if.load = 0; c_if.load_val = '0; c_if.lap = 0;

        // Reset and first ticks
        step(2);
        check("rst_count", 32'(a_if.count_bcd), 32'h000);
        check("rst_tick",  32'(a_if.tick_o), 0);
        check("rst_tc",    32'(a_if.tc_o), 0);
        check("rst_done",  32'(c_if.done), 0);
        rst = 1'b1;
        step(3);
        check("t1_no_tick", 32'(a_if.tick_o), 0);
        check("t1_hold",    32'(a_if.count_bcd), 32'h000);
        step(1);
        check("t1_tick1",   32'(a_if.tick_o), 1);
        check("t1_count1",  32'(a_if.count_bcd), 32'h001);
        step(1);
        check("t1_tick_pulse", 32'(a_if.tick_o), 0);
        step(3);
        check("t1_count2",  32'(a_if.count_bcd), 32'h002);
        check("t1_tick2",   32'(a_if.tick_o), 1);

        // Load with clamped digit; prescaler restarts
        a_if.load_val = 12'h0A3; a_if.load = 1;
        step(1);
        a_if.load = 0;
        check("t4_clamp",   32'(a_if.count_bcd), 32'h093);
        check("t4_no_tick", 32'(a_if.tick_o), 0);
        step(3);
        check("t4_wait",    32'(a_if.tick_o), 0);
        step(1);
        check("t4_tick",    32'(a_if.tick_o), 1);
        check("t4_count",   32'(a_if.count_bcd), 32'h094);

        // Clear+load on the advance cycle, then pause keeps prescaler phase
        step(3);
        a_if.clear = 1; a_if.load = 1; a_if.load_val = 12'h555;
        step(1);
        a_if.clear = 0; a_if.load = 0;
        check("t6_count",   32'(a_if.count_bcd), 32'h000);
        check("t6_no_tick", 32'(a_if.tick_o), 0);
        check("t6_no_tc",   32'(a_if.tc_o), 0);
        step(2);
        a_if.run = 0;
        step(10);
        check("t6_pause_cnt",  32'(a_if.count_bcd), 32'h000);
        check("t6_pause_tick", 32'(a_if.tick_o), 0);
        a_if.run = 1;
        step(1);
        check("t6_resume_wait", 32'(a_if.tick_o), 0);
        step(1);
        check("t6_resume_tick", 32'(a_if.tick_o), 1);
        check("t6_resume_cnt",  32'(a_if.count_bcd), 32'h001);

        // Down through zero wraps to all-9s, up from all-9s wraps to zero
        a_if.dir = 1;
        step(4);
        check("dn_to_zero",    32'(a_if.count_bcd), 32'h000);
        check("dn_to_zero_tc", 32'(a_if.tc_o), 0);
        step(4);
        check("dn_wrap",       32'(a_if.count_bcd), 32'h999);
        check("dn_wrap_tc",    32'(a_if.tc_o), 1);
        check("dn_wrap_tick",  32'(a_if.tick_o), 1);
        a_if.dir = 0;
        step(4);
        check("up_wrap",       32'(a_if.count_bcd), 32'h000);
        check("up_wrap_tc",    32'(a_if.tc_o), 1);

        // Loading the range-end value gives no tc
        a_if.load_val = 12'h999; a_if.load = 1;
        step(1);
        check("ld_end_cnt", 32'(a_if.count_bcd), 32'h999);
        check("ld_end_tc",  32'(a_if.tc_o), 0);

        // Lap hold
        a_if.load_val = 12'h017;
        step(1);
        a_if.load = 0; a_if.lap = 1;
        step(1);
        check("t5_snap", 32'(a_if.disp_bcd), 32'h017);
        step(11);
        check("t5_live",   32'(a_if.count_bcd), 32'h020);
        check("t5_frozen", 32'(a_if.disp_bcd), 32'h017);
        a_if.lap = 0;
        #1;
        check("t5_release", 32'(a_if.disp_bcd), 32'h020);

        // Mid-operation reset
        step(1);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        check("rst2_count", 32'(a_if.count_bcd), 32'h000);
        check("rst2_disp",  32'(a_if.disp_bcd), 32'h000);

        // Two-digit wrap
        b_if.load_val = 8'h98; b_if.load = 1;
        step(1);
        b_if.load = 0; b_if.run = 1;
        check("t2_load", 32'(b_if.count_bcd), 32'h98);
        step(4);
        check("t2_99",    32'(b_if.count_bcd), 32'h99);
        check("t2_99_tc", 32'(b_if.tc_o), 0);
        step(4);
        check("t2_00",      32'(b_if.count_bcd), 32'h00);
        check("t2_00_tc",   32'(b_if.tc_o), 1);
        check("t2_00_tick", 32'(b_if.tick_o), 1);
        step(1);
        check("t2_tc_pulse", 32'(b_if.tc_o), 0);
        b_if.run = 0;

        // Saturating count-down
        c_if.dir = 1; c_if.load_val = 12'h005; c_if.load = 1;
        step(1);
        c_if.load = 0; c_if.run = 1;
        for (int i = 4; i >= 0; i--) begin
            step(4);
            check("t3_down", 32'(c_if.count_bcd), 32'(i));
            check("t3_down_tc", 32'(c_if.tc_o), 0);
        end
        step(4);
        check("t3_sat_tc",   32'(c_if.tc_o), 1);
        check("t3_sat_tick", 32'(c_if.tick_o), 1);
        check("t3_sat_done", 32'(c_if.done), 1);
        check("t3_sat_cnt",  32'(c_if.count_bcd), 32'h000);
        step(1);
        check("t3_tc_once", 32'(c_if.tc_o), 0);
        step(20);
        check("t3_hold_cnt",  32'(c_if.count_bcd), 32'h000);
        check("t3_hold_done", 32'(c_if.done), 1);
        check("t3_hold_tick", 32'(c_if.tick_o), 0);
        c_if.clear = 1;
        step(1);
        c_if.clear = 0;
        check("t3_clr_done", 32'(c_if.done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
